wallace_divider: RTL and testbench

// Sequential restoring divider, the inverse of wallace_multiplier: takes a 2*WIDTH-bit product-range

---
 rtl/wallace_pkg.sv | 18 +
 rtl/wallace_div_step.sv | 20 ++
 rtl/wallace_divider.sv | 149 ++++++++++++++
 tb/tb_wallace_divider.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/wallace_pkg.sv
// Shared definitions for the wallace arithmetic blocks: default width,
// divider FSM state encoding and the iteration-counter width helper.
package wallace_pkg;

   localparam int WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_e;

   // Counter must hold WIDTH-1; keep at least one bit for WIDTH==1.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/wallace_div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder and subtract the divisor when it fits.
module wallace_div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             next_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] trial;

   assign trial   = {rem_in, next_bit};
   assign q_bit   = (trial >= {1'b0, divisor});
   // rem_in < divisor holds every step, so the difference always fits WIDTH bits.
   assign rem_out = q_bit ? WIDTH'(trial - {1'b0, divisor}) : trial[WIDTH-1:0];

endmodule

// File: rtl/wallace_divider.sv
// Sequential restoring divider (2*WIDTH / WIDTH -> WIDTH quotient, remainder).
// DIV_REM_EN: when defined the remainder port carries the true remainder, else it is tied to 0.
module wallace_divider
   import wallace_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               div_by_zero,
   output logic               overflow
);

   localparam int CW = cnt_width(WIDTH);

   div_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic             dbz_q, dbz_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] step_rem;
   logic             step_q;
`ifdef DIV_REM_EN
   logic [WIDTH-1:0] rem_res_q, rem_res_d;
`endif

   // lo_q shifts dividend bits out of the MSB while quotient bits enter at the LSB.
   wallace_div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_q),
      .next_bit(lo_q[WIDTH-1]),
      .divisor (div_q),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      lo_d    = lo_q;
      div_d   = div_q;
      quot_d  = quot_q;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;
`ifdef DIV_REM_EN
      rem_res_d = rem_res_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               div_d = divisor;
               if (divisor == '0) begin
                  dbz_d   = 1'b1;
                  ovf_d   = 1'b0;
                  quot_d  = '1;
`ifdef DIV_REM_EN
                  rem_res_d = dividend[WIDTH-1:0];
`endif
                  state_d = DONE;
               end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
                  dbz_d   = 1'b0;
                  ovf_d   = 1'b1;
                  quot_d  = '1;
`ifdef DIV_REM_EN
                  rem_res_d = '0;
`endif
                  state_d = DONE;
               end else begin
                  rem_d   = dividend[2*WIDTH-1:WIDTH];
                  lo_d    = dividend[WIDTH-1:0];
                  cnt_d   = CW'(WIDTH - 1);
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            rem_d = step_rem;
            lo_d  = {lo_q[WIDTH-2:0], step_q};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               quot_d  = {lo_q[WIDTH-2:0], step_q};
               dbz_d   = 1'b0;
               ovf_d   = 1'b0;
`ifdef DIV_REM_EN
               rem_res_d = step_rem;
`endif
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         lo_q    <= '0;
         div_q   <= '0;
         quot_q  <= '0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
`ifdef DIV_REM_EN
         rem_res_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         lo_q    <= lo_d;
         div_q   <= div_d;
         quot_q  <= quot_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
`ifdef DIV_REM_EN
         rem_res_q <= rem_res_d;
`endif
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign quotient    = quot_q;
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;
`ifdef DIV_REM_EN
   assign remainder   = rem_res_q;
`else
   assign remainder   = '0;
`endif

endmodule

// File: tb/tb_wallace_divider.sv
// Scoreboard bench for wallace_divider (WIDTH=8): directed vectors with
// hand-computed results, backpressure and mid-calculation reset.
module tb_wallace_divider;

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       dbz;
      logic       ovf;
      int         lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] dividend = '0;
   logic [7:0]  divisor = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  quotient;
   logic [7:0]  remainder;
   logic        div_by_zero;
   logic        overflow;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   int   ncyc = 0;
   int   acc_neg = 0;
   logic prev_ov = 1'b0;

   wallace_divider #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .dividend   (dividend),
      .divisor    (divisor),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // The remainder port only carries the true remainder when DIV_REM_EN is defined.
   function automatic logic [7:0] exp_rem(input logic [7:0] r);
`ifdef DIV_REM_EN
      return r;
`else
      return 8'h00 & r;
`endif
   endfunction

   // Monitor: latency is counted in clock edges after the accepting edge
   // (error results appear right after that edge, i.e. in the next cycle).
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ov = 1'b0;
      end else begin
         ncyc++;
         if (in_valid && in_ready) acc_neg = ncyc;
         if (out_valid && !prev_ov) begin
            check("sb_has_item_at_valid", (sb.size() > 0), 1);
            if (sb.size() > 0) check("latency", ncyc - acc_neg - 1, sb[0].lat);
         end
         if (out_valid && out_ready && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("quotient", quotient, e.q);
            check("remainder", remainder, exp_rem(e.r));
            check("div_by_zero", div_by_zero, e.dbz);
            check("overflow", overflow, e.ovf);
         end
         prev_ov = out_valid;
      end
   end

   task automatic issue(input logic [15:0] dd, input logic [7:0] dv);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("in_ready_before_issue", in_ready, 1);
      dividend = dd;
      divisor  = dv;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      dividend = 16'hDEAD;
      divisor  = 8'h5A;
   endtask

   task automatic wait_out_valid();
      int n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("out_valid_within_budget", out_valid, 1);
   endtask

   task automatic do_op(input logic [15:0] dd, input logic [7:0] dv, input logic [7:0] q,
                        input logic [7:0] r, input logic dbz, input logic ovf, input int lat);
      exp_t e;
      e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf; e.lat = lat;
      sb.push_back(e);
      issue(dd, dv);
      wait_out_valid();
      @(posedge clk); #1;
   endtask

   initial begin
      #2;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_quotient", quotient, 0);
      check("rst_remainder", remainder, 0);
      check("rst_flags", {div_by_zero, overflow}, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      do_op(16'h0380, 8'h08, 8'h70, 8'h00, 1'b0, 1'b0, 8);
      do_op(16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0, 8);
      do_op(16'h0070, 8'h07, 8'h10, 8'h00, 1'b0, 1'b0, 8);
      do_op(16'h00AB, 8'h00, 8'hFF, 8'hAB, 1'b1, 1'b0, 0);
      check("hold_dbz_in_idle", div_by_zero, 1);
      check("hold_quot_in_idle", quotient, 8'hFF);
      check("hold_in_ready_idle", in_ready, 1);
      do_op(16'h0800, 8'h08, 8'hFF, 8'h00, 1'b0, 1'b1, 0);
      do_op(16'h07FF, 8'h08, 8'hFF, 8'h07, 1'b0, 1'b0, 8);
      do_op(16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0, 8);

      // Backpressure: hold out_ready low for 5 cycles in DONE and poke in_valid.
      begin
         exp_t e;
         e.q = 8'h36; e.r = 8'h10; e.dbz = 1'b0; e.ovf = 1'b0; e.lat = 8;
         out_ready = 1'b0;
         sb.push_back(e);
         issue(16'h1234, 8'h56);
         wait_out_valid();
         for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            dividend = 16'h0001;
            divisor  = 8'h01;
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_quotient", quotient, 8'h36);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         @(posedge clk); #1;
         check("bp_release_in_ready", in_ready, 1);
         check("bp_release_out_valid", out_valid, 0);
      end

      // Reset pulse during the 4th CALC cycle of 0x1234/0x56; no result expected.
      issue(16'h1234, 8'h56);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_in_ready", in_ready, 1);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_quotient", quotient, 0);
      check("midrst_remainder", remainder, 0);
      check("midrst_flags", {div_by_zero, overflow}, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      do_op(16'h0380, 8'h08, 8'h70, 8'h00, 1'b0, 1'b0, 8);

      begin
         int n = 0;
         while (sb.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
      end
      check("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
